uart_prog_loader: RTL and testbench

Parametrised UART program loader between the `uart` receiver and the memory write port. It assembles received bytes into big-endian words of `WORD_BYTES` bytes and writes them to consecutive addresses starting at `LOAD_BASE`. Loading ends when an all-ones terminator word arrives. Beyond the fixed 2-byte loader it adds a configurable word width, a partial-word resync timeout, overflow protection, a word count and an automatic restart when a new load begins.

---
 rtl/loader_pkg.sv | 16 +
 rtl/rx_word_assembler.sv | 51 +++++
 rtl/uart_prog_loader.sv | 104 ++++++++++
 tb/tb_uart_prog_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state type and terminator detection for the UART program loader
package loader_pkg;

    typedef enum logic {LOAD, DONE} loader_state_t;

    localparam int MAX_WORD_BYTES = 4;
    localparam int MAX_WORD_W     = 8 * MAX_WORD_BYTES;

    // True when the low nbytes bytes of word are all ones
    function automatic logic is_terminator(input logic [MAX_WORD_W-1:0] word, input int nbytes);
        logic [MAX_WORD_W-1:0] mask;
        mask = (nbytes >= MAX_WORD_BYTES) ? '1 : (32'd1 << (8 * nbytes)) - 32'd1;
        return (word & mask) == mask;
    endfunction

endpackage

// File: rtl/rx_word_assembler.sv
// rx_word_assembler: shifts received bytes into big-endian words and discards stale partial words
module rx_word_assembler
    import loader_pkg::*;
#(
    parameter int WORD_BYTES  = 2,
    parameter int TIMEOUT_CYC = 2_700_000
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_wr,
    output logic [8*WORD_BYTES-1:0] word_next,
    output logic                    word_last,
    output logic                    err_timeout
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);

    logic [WORD_W-1:0] shreg;
    logic [1:0]        idx;
    logic [TW-1:0]     idle;
    logic              expire;

    // word_next is the word as it stands once the current byte is shifted in
    always_comb begin
        word_next = (shreg << 8) | WORD_W'(rx_data);
        word_last = rx_data_wr && idx == 2'(WORD_BYTES - 1);
        expire    = !rx_data_wr && idx != 2'd0 && idle == TW'(TIMEOUT_CYC - 1);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            idx         <= '0;
            idle        <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= expire;
            if (rx_data_wr) begin
                shreg <= word_next;
                idx   <= word_last ? 2'd0 : idx + 2'd1;
                idle  <= '0;
            end else begin
                idx  <= expire ? 2'd0 : idx;
                idle <= (expire || idx == 2'd0) ? '0 : idle + TW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: writes UART-received big-endian words to consecutive memory addresses until an all-ones terminator
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int             AW          = 11,
    parameter int             WORD_BYTES  = 2,
    parameter logic [AW-1:0]  LOAD_BASE   = AW'('h300),
    parameter int             TIMEOUT_CYC = 2_700_000
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_wr,
    output logic [AW-1:0]           mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wr_data,
    output logic                    mem_wr,
    output logic [8*WORD_BYTES-1:0] rx_word,
    output logic                    rx_word_v,
    output logic                    done,
    output logic [AW-1:0]           word_count,
    output logic                    err_timeout,
    output logic                    err_ovf
);

    localparam int            WORD_W    = 8 * WORD_BYTES;
    localparam logic [AW-1:0] LAST_ADDR = AW'((1 << AW) - WORD_BYTES);

    loader_state_t     state, state_nxt;
    logic [AW-1:0]     addr_nxt, count_nxt;
    logic [WORD_W-1:0] word_next, wr_data_nxt, rx_word_nxt;
    logic              word_last, term, restart, ovf_nxt, done_nxt, wr_nxt;

    rx_word_assembler #(
        .WORD_BYTES  (WORD_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_asm (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_data_wr  (rx_data_wr),
        .word_next   (word_next),
        .word_last   (word_last),
        .err_timeout (err_timeout)
    );

    // A write in flight is accounted before deciding on the next word, so back-to-back words see a fresh overflow flag
    always_comb begin
        restart     = state == DONE && rx_data_wr;
        term        = is_terminator(MAX_WORD_W'(word_next), WORD_BYTES);
        state_nxt   = state;
        addr_nxt    = mem_addr;
        count_nxt   = word_count;
        ovf_nxt     = err_ovf;
        done_nxt    = done;
        wr_data_nxt = mem_wr_data;
        rx_word_nxt = rx_word;
        wr_nxt      = 1'b0;
        if (mem_wr) begin
            count_nxt = word_count + AW'(1);
            ovf_nxt   = err_ovf || mem_addr == LAST_ADDR;
            addr_nxt  = (mem_addr == LAST_ADDR) ? mem_addr : mem_addr + AW'(WORD_BYTES);
        end
        if (restart) begin
            state_nxt = LOAD;
            done_nxt  = 1'b0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            addr_nxt  = LOAD_BASE;
        end
        if (word_last) begin
            rx_word_nxt = word_next;
            state_nxt   = term ? DONE : state_nxt;
            done_nxt    = term ? 1'b1 : done_nxt;
            addr_nxt    = term ? LOAD_BASE : addr_nxt;
            wr_nxt      = !term && !ovf_nxt;
            wr_data_nxt = wr_nxt ? word_next : mem_wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            mem_addr    <= LOAD_BASE;
            word_count  <= '0;
            err_ovf     <= 1'b0;
            done        <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wr_data <= '0;
            rx_word     <= '0;
            rx_word_v   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_addr    <= addr_nxt;
            word_count  <= count_nxt;
            err_ovf     <= ovf_nxt;
            done        <= done_nxt;
            mem_wr      <= wr_nxt;
            mem_wr_data <= wr_data_nxt;
            rx_word     <= rx_word_nxt;
            rx_word_v   <= word_last;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: three loader configurations checked against a byte-stream reference model
module tb_uart_prog_loader;

    localparam int TC = 100;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic [7:0] rxd [3] = '{default: 8'h00};
    logic       rxw [3] = '{default: 1'b0};

    logic [10:0] a0_addr, a0_wc, a1_addr, a1_wc, a2_addr, a2_wc;
    logic [15:0] a0_wd, a0_rw, a1_wd, a1_rw;
    logic [31:0] a2_wd, a2_rw;
    logic        a0_wr, a0_v, a0_done, a0_to, a0_ovf;
    logic        a1_wr, a1_v, a1_done, a1_to, a1_ovf;
    logic        a2_wr, a2_v, a2_done, a2_to, a2_ovf;

    uart_prog_loader #(.AW(11), .WORD_BYTES(2), .LOAD_BASE(11'h300), .TIMEOUT_CYC(TC)) u_dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rxd[0]), .rx_data_wr(rxw[0]),
        .mem_addr(a0_addr), .mem_wr_data(a0_wd), .mem_wr(a0_wr), .rx_word(a0_rw), .rx_word_v(a0_v),
        .done(a0_done), .word_count(a0_wc), .err_timeout(a0_to), .err_ovf(a0_ovf));

    uart_prog_loader #(.AW(11), .WORD_BYTES(2), .LOAD_BASE(11'h7FC), .TIMEOUT_CYC(TC)) u_dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rxd[1]), .rx_data_wr(rxw[1]),
        .mem_addr(a1_addr), .mem_wr_data(a1_wd), .mem_wr(a1_wr), .rx_word(a1_rw), .rx_word_v(a1_v),
        .done(a1_done), .word_count(a1_wc), .err_timeout(a1_to), .err_ovf(a1_ovf));

    uart_prog_loader #(.AW(11), .WORD_BYTES(4), .LOAD_BASE(11'h300), .TIMEOUT_CYC(TC)) u_dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rxd[2]), .rx_data_wr(rxw[2]),
        .mem_addr(a2_addr), .mem_wr_data(a2_wd), .mem_wr(a2_wr), .rx_word(a2_rw), .rx_word_v(a2_v),
        .done(a2_done), .word_count(a2_wc), .err_timeout(a2_to), .err_ovf(a2_ovf));

    logic [31:0] o_addr [3], o_wd [3], o_rw [3], o_wc [3];
    logic        o_wr [3], o_v [3], o_done [3], o_to [3], o_ovf [3];
    assign o_addr[0] = 32'(a0_addr); assign o_wd[0] = 32'(a0_wd); assign o_rw[0] = 32'(a0_rw); assign o_wc[0] = 32'(a0_wc);
    assign o_addr[1] = 32'(a1_addr); assign o_wd[1] = 32'(a1_wd); assign o_rw[1] = 32'(a1_rw); assign o_wc[1] = 32'(a1_wc);
    assign o_addr[2] = 32'(a2_addr); assign o_wd[2] = a2_wd;      assign o_rw[2] = a2_rw;      assign o_wc[2] = 32'(a2_wc);
    assign o_wr[0] = a0_wr; assign o_v[0] = a0_v; assign o_done[0] = a0_done; assign o_to[0] = a0_to; assign o_ovf[0] = a0_ovf;
    assign o_wr[1] = a1_wr; assign o_v[1] = a1_v; assign o_done[1] = a1_done; assign o_to[1] = a1_to; assign o_ovf[1] = a1_ovf;
    assign o_wr[2] = a2_wr; assign o_v[2] = a2_v; assign o_done[2] = a2_done; assign o_to[2] = a2_to; assign o_ovf[2] = a2_ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tocnt [3] = '{default: 0};
    logic [63:0] wlog [$];
    logic [63:0] expq [$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_wr[i]) wlog.push_back({8'(i), 24'(o_addr[i]), o_wd[i]});
            if (o_to[i]) tocnt[i] <= tocnt[i] + 1;
        end
    end

    // Reference model: loader behaviour expressed over the byte stream and idle gaps
    int          m_n [3], m_to [3] = '{default: 0}, last_cap [3] = '{default: 0};
    logic [31:0] m_word [3], m_rxw [3], m_addr [3], m_cnt [3];
    bit          m_ovf [3], m_done [3];

    function automatic int wb(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    function automatic logic [31:0] base(input int i);
        return (i == 1) ? 32'h7FC : 32'h300;
    endfunction

    function automatic logic [31:0] wmask(input int i);
        return (wb(i) == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * wb(i))) - 32'd1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0; m_word[i] = '0; m_rxw[i] = '0; m_addr[i] = base(i);
            m_cnt[i] = '0; m_ovf[i] = 1'b0; m_done[i] = 1'b0;
        end
    endfunction

    function automatic void feed(input int i, input logic [7:0] b, input int gap);
        if (gap >= TC && m_n[i] != 0) begin
            m_n[i] = 0;
            m_to[i]++;
        end
        if (m_done[i]) begin
            m_done[i] = 1'b0; m_cnt[i] = '0; m_ovf[i] = 1'b0; m_addr[i] = base(i);
        end
        m_word[i] = ((m_word[i] << 8) | 32'(b)) & wmask(i);
        m_n[i]++;
        if (m_n[i] == wb(i)) begin
            m_n[i]   = 0;
            m_rxw[i] = m_word[i];
            if (m_word[i] == wmask(i)) begin
                m_done[i] = 1'b1;
                m_addr[i] = base(i);
            end else if (!m_ovf[i]) begin
                expq.push_back({8'(i), 24'(m_addr[i]), m_word[i]});
                m_cnt[i]++;
                if (m_addr[i] == 32'(2048 - wb(i))) m_ovf[i] = 1'b1;
                else m_addr[i] += 32'(wb(i));
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input int i, input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rxd[i] = b;
        rxw[i] = 1'b1;
        tick();
        rxw[i] = 1'b0;
        feed(i, b, cyc - last_cap[i] - 1);
        last_cap[i] = cyc;
    endtask

    task automatic verify(input int i, input string tag);
        repeat (3) tick();
        chk({tag, "_nwr"}, 64'(wlog.size()), 64'(expq.size()));
        for (int k = 0; k < wlog.size() && k < expq.size(); k++) chk({tag, "_wr"}, wlog[k], expq[k]);
        chk({tag, "_done"}, 64'(o_done[i]), 64'(m_done[i]));
        chk({tag, "_wc"}, 64'(o_wc[i]), 64'(m_cnt[i]));
        chk({tag, "_addr"}, 64'(o_addr[i]), 64'(m_addr[i]));
        chk({tag, "_ovf"}, 64'(o_ovf[i]), 64'(m_ovf[i]));
        chk({tag, "_rxword"}, 64'(o_rw[i]), 64'(m_rxw[i]));
        chk({tag, "_timeouts"}, 64'(tocnt[i]), 64'(m_to[i]));
        wlog.delete();
        expq.delete();
    endtask

    task automatic reset_values(input int i, input string tag);
        chk({tag, "_addr"}, 64'(o_addr[i]), 64'(base(i)));
        chk({tag, "_done"}, 64'(o_done[i]), 64'd0);
        chk({tag, "_wc"}, 64'(o_wc[i]), 64'd0);
        chk({tag, "_wr"}, 64'(o_wr[i]), 64'd0);
        chk({tag, "_wd"}, 64'(o_wd[i]), 64'd0);
        chk({tag, "_rxword"}, 64'(o_rw[i]), 64'd0);
        chk({tag, "_rxv"}, 64'(o_v[i]), 64'd0);
        chk({tag, "_to"}, 64'(o_to[i]), 64'd0);
        chk({tag, "_ovf"}, 64'(o_ovf[i]), 64'd0);
    endtask

    initial begin
        int lat;
        #2 rst_n = 1'b0;
        #20;
        reset_values(0, "rst0");
        reset_values(1, "rst1");
        reset_values(2, "rst2");
        #3 rst_n = 1'b1;
        model_reset();
        tick();

        // Basic two-word load with write timing
        send(0, 8'h12, 0);
        send(0, 8'h34, 0);
        chk("t1_wr_pulse", 64'(o_wr[0]), 64'd1);
        chk("t1_wr_addr", 64'(o_addr[0]), 64'h300);
        chk("t1_wr_data", 64'(o_wd[0]), 64'h1234);
        chk("t1_rxv", 64'(o_v[0]), 64'd1);
        send(0, 8'h56, 0);
        chk("t1_wr_low", 64'(o_wr[0]), 64'd0);
        chk("t1_addr_adv", 64'(o_addr[0]), 64'h302);
        chk("t1_wc_adv", 64'(o_wc[0]), 64'd1);
        send(0, 8'h78, 0);
        send(0, 8'hFF, 0);
        send(0, 8'hFF, 0);
        chk("t1_done_rise", 64'(o_done[0]), 64'd1);
        chk("t1_term_nowr", 64'(o_wr[0]), 64'd0);
        verify(0, "t1");

        // Restart from DONE
        send(0, 8'hAB, 2);
        chk("t3_done_fall", 64'(o_done[0]), 64'd0);
        send(0, 8'hCD, 0);
        chk("t3_wr", 64'(o_wr[0]), 64'd1);
        chk("t3_wr_addr", 64'(o_addr[0]), 64'h300);
        chk("t3_wr_data", 64'(o_wd[0]), 64'hABCD);
        verify(0, "t3");

        // Partial word timeout, its latency, and the expiry-cycle boundary
        send(0, 8'h12, 0);
        lat = 0;
        for (int k = 1; k <= 3 * TC && lat == 0; k++) begin
            tick();
            if (o_to[0]) lat = k;
        end
        chk("t2_to_latency", 64'(lat), 64'(TC));
        send(0, 8'h34, 20);
        send(0, 8'h56, 0);
        send(0, 8'h77, 0);
        send(0, 8'h88, TC - 1);
        send(0, 8'h99, 0);
        send(0, 8'hAA, TC);
        send(0, 8'hBB, 0);
        send(0, 8'hFF, 0);
        send(0, 8'hFF, 0);
        verify(0, "t2");

        // Overflow near the top of the address space
        foreach (rxd[k]) if (k < 0) rxd[k] = 8'h00;
        send(1, 8'h11, 0); send(1, 8'h11, 0);
        send(1, 8'h22, 0); send(1, 8'h22, 0);
        send(1, 8'h33, 0); send(1, 8'h33, 0);
        send(1, 8'hFF, 0); send(1, 8'hFF, 0);
        verify(1, "t4");

        // Four-byte words
        send(2, 8'h01, 0); send(2, 8'h02, 0); send(2, 8'h03, 0); send(2, 8'h04, 0);
        send(2, 8'hFF, 0); send(2, 8'hFF, 0); send(2, 8'hFF, 0); send(2, 8'hFF, 0);
        verify(2, "t5");

        // Randomised streams with occasional terminators and long gaps
        for (int r = 0; r < 6; r++) begin
            int inst, n;
            inst = (r % 2 == 0) ? 0 : 2;
            n = 20 + $urandom_range(0, 20);
            for (int k = 0; k < n; k++)
                send(inst, ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom),
                     ($urandom_range(0, 9) == 0) ? $urandom_range(TC - 2, TC + 2) : $urandom_range(0, 3));
            for (int k = 0; k < wb(inst); k++) send(inst, 8'hFF, 0);
            verify(inst, "rnd");
        end

        // Asynchronous reset in the middle of a word
        send(0, 8'h12, 0);
        #2 rst_n = 1'b0;
        #1;
        reset_values(0, "t6_rst");
        chk("t6_ovf1_clr", 64'(o_ovf[1]), 64'd0);
        #10 rst_n = 1'b1;
        model_reset();
        tick();
        send(0, 8'h34, 0);
        send(0, 8'h56, 0);
        verify(0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
